// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// baud divider calculation used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud/oversample tick divider: one-cycle tick every DIV clocks while enabled,
// synchronously cleared to phase 0. DIV == 1 gives a tick on every enabled cycle.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise wrap at DIV-1 while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: two-flop synchronizer, oversampled start/data/stop FSM
// with 3-sample majority vote, and a one-entry valid/ready holding register.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned   DIV     = baud_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned   PW      = $clog2(OVERSAMPLE);
  localparam int unsigned   BW      = $clog2(DATA_BITS);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_S0   = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_S1   = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_S2   = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  uart_rx_state_e       state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 tick, tick_clr, vote, vote_now, load;

  assign rx_s = sync_q[1];
  assign busy = (state_q != IDLE);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (busy),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[0], rx};
  end

  assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign vote_now = tick && (phase_q == PH_S2);

  // Frame FSM, sampling/shift datapath and holding register next-state.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    smp_d    = smp_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    valid_d  = valid_q;
    fe_d     = 1'b0;
    ov_d     = 1'b0;
    load     = 1'b0;
    tick_clr = 1'b0;

    if (state_q == IDLE) begin
      if (!rx_s) begin
        state_d  = START;
        phase_d  = '0;
        tick_clr = 1'b1;
      end
    end else if (tick) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      if (phase_q == PH_S0) smp_d[0] = rx_s;
      if (phase_q == PH_S1) smp_d[1] = rx_s;
      case (state_q)
        START: begin
          if (vote_now && vote) begin
            state_d = IDLE;
          end else if (phase_q == PH_LAST) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (vote_now) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          if (phase_q == PH_LAST) begin
            if (bit_q == BIT_LAST) state_d = STOP;
            else                   bit_d   = bit_q + 1'b1;
          end
        end
        STOP: begin
          if (vote_now) begin
            state_d = IDLE;
            if (vote) load = 1'b1;
            else      fe_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (load) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      ov_d    = valid_q && !ready;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

UART receiver for the lab board's serial link. It runs on the 100 MHz PLL clock and turns the asynchronous `rx` pin into bytes handed to the core over a valid/ready handshake. The frame format is 8N1, LSB first, and the receiver uses 16× oversampling with a 3-sample majority vote. It is the receiving end of the same serial protocol that `tx` drives back to the host.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 100_000_000. Frequency of `clk`.
- `BAUD`, default 115_200. Line rate.
- `OVERSAMPLE`, default 16. Ticks per bit. Must be ≥ 8 and even.

Ports:
- `clk`, in, 1. Single clock. All logic is in this domain.
- `rst_n`, in, 1. Asynchronous, active-low reset.
- `rx`, in, 1. Raw serial line. Idle level is 1.
- `data`, out, 8. Received byte. Stable while `valid` is high.
- `valid`, out, 1. The byte in the holding register is available.
- `ready`, in, 1. Consumer accepts the byte when `valid && ready`.
- `frame_err`, out, 1. One-cycle pulse: the stop bit was sampled as 0.
- `overrun`, out, 1. One-cycle pulse: a new byte completed while `valid` was high and no handshake occurred that cycle.
- `busy`, out, 1. High whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops that reset to 1. The synchronized value is `rx_s`. All logic below uses `rx_s`.
- **Tick generator:**
  - `DIV = (CLK_FREQ_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE)`, i.e. rounded.
  - Counter width is `$clog2(DIV)`. It emits a one-cycle `tick` every `DIV` clocks.
  - It free-runs only while not in IDLE, and is cleared to 0 on IDLE→START.
  - `DIV == 1` is legal: `tick` is high every cycle.
- **Phase counter:** 0..`OVERSAMPLE-1`, advanced on `tick`. Samples are taken at phases `OVERSAMPLE/2-1`, `OVERSAMPLE/2` and `OVERSAMPLE/2+1`. The majority of the three is the bit value, committed at the last of those phases.
- **FSM states:**
  - **IDLE:** on `rx_s == 0`, go to START with phase = 0.
  - **START:** at the mid-bit vote, a result of 1 means a glitch: return to IDLE with no flags. A result of 0 continues. At phase `OVERSAMPLE-1` go to DATA with bit index 0.
  - **DATA:** the vote result is shifted in LSB-first, so bit 0 lands in `shreg[0]`. After the vote on bit index 7, at phase `OVERSAMPLE-1`, go to STOP.
  - **STOP:** act on the vote, then go straight to IDLE without waiting out the rest of the stop bit. This lets back-to-back frames resync on the next falling edge.
    - Vote = 1: load `shreg` into the holding register and set `valid`.
    - Vote = 0: pulse `frame_err` and discard the byte.
- **Holding register:** one entry.
  - `valid` clears on `valid && ready`.
  - Load and handshake in the same cycle: the new byte wins, `valid` stays 1, and there is no overrun.
  - Load with `valid` high and no handshake: the new byte overwrites the old one and `overrun` pulses.
- **Reset:** takes effect immediately, including mid-frame. The partial frame is dropped. After reset the block waits for the next falling edge of `rx_s`.

## Timing
- **Reset values:** `data` = 8'h00, `valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0. Synchronizer flops = 1. FSM = IDLE.
- **Input latency:** 2 `clk` from an `rx` pin edge to `rx_s`.
- **Output latency:** `valid` rises, or `frame_err` pulses, 1 `clk` after the tick that carries the stop-bit vote. That vote is the third mid-bit sample of the stop bit.
- **Frame length:** about 9.5 bit times from the falling edge of the start bit to `valid`.
- **Pulse widths:** `frame_err` and `overrun` are exactly 1 cycle each. They never assert in the same cycle.
- **Byte-rate limit:** `ready` may be held low indefinitely. One byte is buffered; the next completed frame overruns.
- **Line held low:** a break (line stuck at 0) gives `frame_err`. The FSM then returns to IDLE and sees `rx_s == 0`, so it re-enters START immediately. The result is repeated `frame_err` pulses, which is acceptable.

## Structure
- Shared package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_e`
  - function `baud_div(clk_hz, baud, os)`, shared with the transmitter
  - localparam `DATA_BITS = 8`
- Sub-module `uart_baud_tick` holds the divider with an enable and a synchronous clear. The TX side reuses it with `OVERSAMPLE = 1`.
- The synchronizer, FSM and holding register are all in `uart_rx_8n1`.

## Test plan
The bench uses `CLK_FREQ_HZ = 1_600_000`, `BAUD = 100_000` and `OVERSAMPLE = 16`. This gives `DIV = 1`, so one bit lasts 16 clk.

1. **Basic frames:** send 8'hA5 then 8'h3C, with `ready` = 1. Expect `valid` pulses with `data` = A5 then 3C. Each `valid` comes 1 clk after the stop vote, about 152 clk after the start edge. No flags.
2. **Glitch rejection:** drive a 4-clk low pulse on idle `rx`. Expect a return to IDLE, no `valid`, no `frame_err`, and `busy` low within 16 clk. Also check that a single-sample spike inside a data bit of 8'h00 still gives `data` = 00.
3. **Framing error:** send 8'h55 with the stop bit driven 0. Expect a `frame_err` pulse of 1 clk, `valid` staying 0, and the next good frame (8'h81) received correctly.
4. **Overrun:** hold `ready` = 0 and send 8'h11 then 8'h22. Expect `overrun` to pulse when the second byte completes. `data` = 22 and `valid` stays 1. Raise `ready`: `valid` drops the next cycle.
5. **Simultaneous load and handshake:** assert `ready` exactly on the cycle the second byte loads. Expect `data` to be updated, `valid` to stay 1, and no `overrun`.
6. **Reset mid-frame:** assert `rst_n` = 0 during bit 4 of 8'hF0, then release. Expect all outputs at their reset values and no `valid` for the partial frame. The next frame, 8'h0F, is received correctly.
